hood_mode_ctrl: RTL
===================

# hood_mode_ctrl

Mode sequencer for the range hood. Turns debounced single-cycle button pulses into the operating mode: off, standby, extraction at levels 1–3, timed return from level 3, and timed self-clean. It drives `state` and `power_on` for the timekeeping/work-hour counter and `fan_level` for the motor driver, and enforces the once-per-power-cycle limit on level 3.

## Interface
- `TICKS_PER_SEC`, default 100: `clk` cycles per countdown second (range 2–65535).
- `HURRICANE_SEC`, default 60: level-3 run time in seconds (1–255).
- `RETURN_SEC`, default 60: delay before standby after menu is pressed at level 3 (1–255).
- `CLEAN_SEC`, default 180: self-clean duration in seconds (1–255).

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-low reset.
- `btn_power` input 1: power toggle pulse.
- `btn_menu` input 1: return-to-standby pulse.
- `btn_level1`, `btn_level2`, `btn_level3` input 1 each: extraction level request pulses.
- `btn_clean` input 1: self-clean request pulse.
- `state` output 2: 00 off, 10 standby, 01 extracting (including return wait), 11 cleaning.
- `power_on` output 1: high in every state except off.
- `fan_level` output 2: 0 stopped, 1–3 motor level.
- `countdown` output 8: seconds remaining in a timed phase, 0 otherwise.
- `level3_used` output 1: level 3 already used in this power cycle.
- `clean_done` output 1: one-cycle pulse when a clean completes.

## Operation
- Internal states are OFF, STANDBY, EXTRACT, RETURN and CLEAN. RETURN reports `state`=01.
- One event is accepted per cycle. Priority is power > menu > level1 > level2 > level3 > clean. Lower-priority pulses in the same cycle are dropped.
- `btn_power` in any state other than OFF goes to OFF. This clears `fan_level`, `countdown`, `level3_used` and the prescaler.
- `btn_power` in OFF goes to STANDBY. All other buttons are ignored in OFF.
- STANDBY:
  - level1 or level2 goes to EXTRACT at that level.
  - level3 goes to EXTRACT at level 3 only if `level3_used`=0. It sets `level3_used`=1 and loads `countdown`=HURRICANE_SEC. If `level3_used`=1 the pulse is ignored.
  - clean goes to CLEAN with `fan_level`=0 and loads `countdown`=CLEAN_SEC.
- EXTRACT at level 1 or 2:
  - level1 and level2 switch the level directly.
  - level3 follows the STANDBY rule.
  - menu goes to STANDBY at once.
  - clean is ignored.
- EXTRACT at level 3:
  - level1, level2 and level3 are ignored.
  - menu goes to RETURN and reloads `countdown`=RETURN_SEC. Fan stays at 3.
  - When the countdown expires, go to EXTRACT level 2 and set `countdown`=0.
- RETURN:
  - Fan stays at 3 and every button except power is ignored.
  - When the countdown expires, go to STANDBY with `fan_level`=0.
- CLEAN:
  - Every button except power is ignored.
  - When the countdown expires, go to STANDBY and pulse `clean_done`.
  - Exiting CLEAN through power does not pulse `clean_done`.
- Prescaler: a 16-bit counter that cycles 0..TICKS_PER_SEC-1 while a countdown is active. It is zeroed on every countdown load.

## Timing
- All outputs are registered. A button pulse in cycle N is reflected in the outputs at cycle N+1.
- Timed phase with load value L: `countdown` decrements every TICKS_PER_SEC cycles after the load edge. The exit transition happens in the same cycle that `countdown` would go 1→0. The phase therefore lasts exactly L*TICKS_PER_SEC cycles, and `countdown` never shows 0 inside a timed state.
- A reload such as menu at level 3 restarts the prescaler, so the new phase also lasts a full L*TICKS_PER_SEC.
- If a button arrives in the expiry cycle, expiry wins. The one exception is power, which always wins.
- Reset (while `reset`=0 at a clock edge) sets `state`=00, `power_on`=0, `fan_level`=0, `countdown`=0, `level3_used`=0, `clean_done`=0 and the prescaler to 0. Reset mid-countdown aborts without a `clean_done` pulse.
- `clean_done` is high for exactly 1 cycle, coincident with the first cycle of `state`=10.

## Test plan
Benches use TICKS_PER_SEC=4, HURRICANE_SEC=3, RETURN_SEC=2 and CLEAN_SEC=5.
- Reset, then power, then level2: `state` goes 00→10→01 and `fan_level`=2. Then menu gives `state`=10 and `fan_level`=0.
- In standby, press level3: `fan_level`=3 and `countdown`=3. After exactly 12 cycles, `fan_level`=2 and `countdown`=0. Menu, then level3 again: `fan_level`=0, `state`=10 and `level3_used`=1. Power off then on, then level3: the level is accepted.
- At level 3, press menu 5 cycles after entry: `countdown`=2, fan stays at 3, and after 8 cycles `state`=10. A level1 pulse during RETURN has no effect.
- Clean from standby: `state`=11 and `fan_level`=0 for 20 cycles, then `state`=10 with a 1-cycle `clean_done`. Repeat, pressing power in cycle 10: `state`=00 and `clean_done` stays 0.
- Level1, level3 and clean pulsed in the same cycle from standby: result is `fan_level`=1. Power plus menu in the same cycle from EXTRACT: result is `state`=00.
- Hold `reset`=0 mid-clean: at the next edge all outputs take their reset values, and `reset`=0 with no clock edge changes nothing.

Source files
------------

// File: rtl/hood_mode_ctrl_if.sv
// Button pulses into the hood mode sequencer and its registered mode outputs.
// The master drives the buttons; the slave is the sequencer.
interface hood_mode_ctrl_if;
    logic       btn_power;
    logic       btn_menu;
    logic       btn_level1;
    logic       btn_level2;
    logic       btn_level3;
    logic       btn_clean;
    logic [1:0] state;
    logic       power_on;
    logic [1:0] fan_level;
    logic [7:0] countdown;
    logic       level3_used;
    logic       clean_done;

    modport master (
        output btn_power, btn_menu, btn_level1, btn_level2, btn_level3, btn_clean,
        input  state, power_on, fan_level, countdown, level3_used, clean_done
    );

    modport slave (
        input  btn_power, btn_menu, btn_level1, btn_level2, btn_level3, btn_clean,
        output state, power_on, fan_level, countdown, level3_used, clean_done
    );
endinterface

// File: rtl/hood_mode_ctrl.sv
// Range-hood mode sequencer: off/standby/extract 1-3/timed return/timed self-clean.
// One-cycle latency from button pulse to registered outputs; no backpressure, pulses are never queued.
module hood_mode_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned HURRICANE_SEC = 60,
    parameter int unsigned RETURN_SEC    = 60,
    parameter int unsigned CLEAN_SEC     = 180
) (
    input  logic             clk,
    input  logic             reset,
    hood_mode_ctrl_if.slave  bus
);

    // Low two bits of each encoding are the reported state code.
    typedef enum logic [2:0] {
        S_OFF     = 3'b000,
        S_STANDBY = 3'b010,
        S_EXTRACT = 3'b001,
        S_RETURN  = 3'b101,
        S_CLEAN   = 3'b011
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE, EV_POWER, EV_MENU, EV_L1, EV_L2, EV_L3, EV_CLEAN
    } ev_t;

    localparam logic [15:0] TICK_LAST = 16'(TICKS_PER_SEC - 1);
    localparam logic [7:0]  HURR_LD   = 8'(HURRICANE_SEC);
    localparam logic [7:0]  RET_LD    = 8'(RETURN_SEC);
    localparam logic [7:0]  CLEAN_LD  = 8'(CLEAN_SEC);

    state_t      st;
    ev_t         ev;
    logic [15:0] presc;
    logic [7:0]  cnt;
    logic [1:0]  fan;
    logic        used;
    logic        pwr;
    logic        done;
    logic        tick;
    logic        expire;

    always_comb begin
        ev = EV_NONE;
        if      (bus.btn_power)  ev = EV_POWER;
        else if (bus.btn_menu)   ev = EV_MENU;
        else if (bus.btn_level1) ev = EV_L1;
        else if (bus.btn_level2) ev = EV_L2;
        else if (bus.btn_level3) ev = EV_L3;
        else if (bus.btn_clean)  ev = EV_CLEAN;
    end

    // A nonzero countdown is exactly the set of timed phases.
    assign tick   = (cnt != 8'd0) && (presc == TICK_LAST);
    assign expire = tick && (cnt == 8'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            st    <= S_OFF;
            pwr   <= 1'b0;
            fan   <= 2'd0;
            cnt   <= 8'd0;
            used  <= 1'b0;
            done  <= 1'b0;
            presc <= 16'd0;
        end else begin
            done <= 1'b0;
            if (ev == EV_POWER) begin
                if (st == S_OFF) begin
                    st  <= S_STANDBY;
                    pwr <= 1'b1;
                end else begin
                    st    <= S_OFF;
                    pwr   <= 1'b0;
                    fan   <= 2'd0;
                    cnt   <= 8'd0;
                    used  <= 1'b0;
                    presc <= 16'd0;
                end
            end else if (expire) begin
                cnt   <= 8'd0;
                presc <= 16'd0;
                case (st)
                    S_EXTRACT: fan <= 2'd2;
                    S_RETURN: begin
                        st  <= S_STANDBY;
                        fan <= 2'd0;
                    end
                    S_CLEAN: begin
                        st   <= S_STANDBY;
                        done <= 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                if (tick) begin
                    cnt   <= cnt - 8'd1;
                    presc <= 16'd0;
                end else if (cnt != 8'd0) begin
                    presc <= presc + 16'd1;
                end
                // Standby has fan 0, so only extraction at level 3 takes the else branch.
                if ((st == S_STANDBY || st == S_EXTRACT) && fan != 2'd3) begin
                    case (ev)
                        EV_L1: begin
                            st  <= S_EXTRACT;
                            fan <= 2'd1;
                        end
                        EV_L2: begin
                            st  <= S_EXTRACT;
                            fan <= 2'd2;
                        end
                        EV_L3: if (!used) begin
                            st    <= S_EXTRACT;
                            fan   <= 2'd3;
                            used  <= 1'b1;
                            cnt   <= HURR_LD;
                            presc <= 16'd0;
                        end
                        EV_MENU: if (st == S_EXTRACT) begin
                            st  <= S_STANDBY;
                            fan <= 2'd0;
                        end
                        EV_CLEAN: if (st == S_STANDBY) begin
                            st    <= S_CLEAN;
                            fan   <= 2'd0;
                            cnt   <= CLEAN_LD;
                            presc <= 16'd0;
                        end
                        default: ;
                    endcase
                end else if (st == S_EXTRACT && ev == EV_MENU) begin
                    st    <= S_RETURN;
                    cnt   <= RET_LD;
                    presc <= 16'd0;
                end
            end
        end
    end

    assign bus.state       = st[1:0];
    assign bus.power_on    = pwr;
    assign bus.fan_level   = fan;
    assign bus.countdown   = cnt;
    assign bus.level3_used = used;
    assign bus.clean_done  = done;

endmodule
